// File: rtl/exp5_fluxo_dados.sv
// -----------------------------------------------------------------------------
// exp5_fluxo_dados
// Datapath for the sequence-memory game. It runs the counter and move-register
// commands from the control unit and returns the status flags fim, jogada and
// igual to it.
//
// Ports:
//   clock        system clock; all state changes on its rising edge
//   reset        asynchronous, active-low reset (0 = reset)
//   zeraC        synchronous clear of the position counter (wins over contaC)
//   contaC       synchronous increment of the position counter (wraps)
//   zeraR        synchronous clear of the move register (wins over registraR)
//   registraR    synchronous load of the move register from chaves
//   chaves       player keys: one-hot while pressed, 0 when released
//   fim          high while the counter sits at the last address
//   jogada       one-cycle pulse on the first cycle a key press is seen
//   igual        move register equals the ROM word at the current address
//   db_contagem  current counter value (debug display)
//   db_memoria   ROM word at the current address (debug display)
//   db_jogada    move register contents (debug display)
// -----------------------------------------------------------------------------
module exp5_fluxo_dados #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              zeraC,
    input  logic              contaC,
    input  logic              zeraR,
    input  logic              registraR,
    input  logic [DATA_W-1:0] chaves,
    output logic              fim,
    output logic              jogada,
    output logic              igual,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [DATA_W-1:0] db_memoria,
    output logic [DATA_W-1:0] db_jogada
);

    logic [ADDR_W-1:0] count_r;
    logic [DATA_W-1:0] move_r;
    logic              press_hist_r;
    logic [DATA_W-1:0] rom_word_s;
    logic              press_s;

    // Fixed game sequence. Addresses outside the sixteen listed words read 0,
    // which can never match a move, so a wider ADDR_W fails safe.
    function automatic logic [DATA_W-1:0] rom_lookup(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] word;
        case (addr)
            ADDR_W'(0):  word = DATA_W'(4'b0001);
            ADDR_W'(1):  word = DATA_W'(4'b0010);
            ADDR_W'(2):  word = DATA_W'(4'b0100);
            ADDR_W'(3):  word = DATA_W'(4'b1000);
            ADDR_W'(4):  word = DATA_W'(4'b0100);
            ADDR_W'(5):  word = DATA_W'(4'b0010);
            ADDR_W'(6):  word = DATA_W'(4'b0001);
            ADDR_W'(7):  word = DATA_W'(4'b0001);
            ADDR_W'(8):  word = DATA_W'(4'b0010);
            ADDR_W'(9):  word = DATA_W'(4'b0010);
            ADDR_W'(10): word = DATA_W'(4'b0100);
            ADDR_W'(11): word = DATA_W'(4'b0100);
            ADDR_W'(12): word = DATA_W'(4'b1000);
            ADDR_W'(13): word = DATA_W'(4'b1000);
            ADDR_W'(14): word = DATA_W'(4'b0001);
            ADDR_W'(15): word = DATA_W'(4'b0100);
            default:     word = {DATA_W{1'b0}};
        endcase
        return word;
    endfunction

    // Position counter: clear beats increment, increment wraps naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {ADDR_W{1'b0}};
        end else if (zeraC) begin
            count_r <= {ADDR_W{1'b0}};
        end else if (contaC) begin
            count_r <= count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Move register: clear beats load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            move_r <= {DATA_W{1'b0}};
        end else if (zeraR) begin
            move_r <= {DATA_W{1'b0}};
        end else if (registraR) begin
            move_r <= chaves;
        end else begin
            move_r <= move_r;
        end
    end

    // Edge-detector history: remembers whether any key was down last cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            press_hist_r <= 1'b0;
        end else begin
            press_hist_r <= press_s;
        end
    end

    // Asynchronous ROM read and status flags derived from the current state.
    always_comb begin
        rom_word_s = rom_lookup(count_r);
        press_s    = |chaves;
        jogada     = press_s & ~press_hist_r;
        fim        = (count_r == {ADDR_W{1'b1}});
        igual      = (move_r == rom_word_s);
    end

    assign db_contagem = count_r;
    assign db_memoria  = rom_word_s;
    assign db_jogada   = move_r;

endmodule

// File: tb/tb_exp5_fluxo_dados.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for exp5_fluxo_dados. Inputs change 1 ns after
// each rising edge; outputs are sampled there as well, away from the edge.
// -----------------------------------------------------------------------------
module tb_exp5_fluxo_dados;

    logic       clock;
    logic       reset;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic [3:0] chaves;
    logic       fim;
    logic       jogada;
    logic       igual;
    logic [3:0] db_contagem;
    logic [3:0] db_memoria;
    logic [3:0] db_jogada;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] rom_exp [16] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
        4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100
    };

    exp5_fluxo_dados #(.ADDR_W(4), .DATA_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .zeraC       (zeraC),
        .contaC      (contaC),
        .zeraR       (zeraR),
        .registraR   (registraR),
        .chaves      (chaves),
        .fim         (fim),
        .jogada      (jogada),
        .igual       (igual),
        .db_contagem (db_contagem),
        .db_memoria  (db_memoria),
        .db_jogada   (db_jogada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        zeraC = 1'b0; contaC = 1'b0; zeraR = 1'b0; registraR = 1'b0; chaves = 4'b0000;
    endtask

    task automatic set_counter(input int n);
        zeraC = 1'b1; tick(); zeraC = 1'b0;
        contaC = 1'b1;
        for (int i = 0; i < n; i++) tick();
        contaC = 1'b0;
    endtask

    task automatic test_reset();
        // power-on reset
        reset = 1'b0; idle_inputs();
        #2;
        tests_run++;
        if (db_contagem !== 4'd0 || db_jogada !== 4'b0000 || db_memoria !== 4'b0001 ||
            fim !== 1'b0 || jogada !== 1'b0 || igual !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_por: cnt=%h jog=%b mem=%b fim=%b jogada=%b igual=%b, want 0 0000 0001 0 0 0",
                     db_contagem, db_jogada, db_memoria, fim, jogada, igual);
        end
        @(posedge clock); #1; reset = 1'b1;
        // build mid-round state: counter 5, register 0100
        set_counter(5);
        chaves = 4'b0100; registraR = 1'b1; tick(); registraR = 1'b0; chaves = 4'b0000;
        tests_run++;
        if (db_contagem !== 4'd5 || db_jogada !== 4'b0100) begin
            tests_failed++;
            $display("FAIL reset_setup: cnt=%0d jog=%b, want 5 0100", db_contagem, db_jogada);
        end
        // asynchronous abort with commands active, checked before any edge
        contaC = 1'b1; registraR = 1'b1; reset = 1'b0;
        #1;
        tests_run++;
        if (db_contagem !== 4'd0 || db_jogada !== 4'b0000 || db_memoria !== 4'b0001 ||
            fim !== 1'b0 || jogada !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: cnt=%h jog=%b mem=%b fim=%b jogada=%b, want 0 0000 0001 0 0",
                     db_contagem, db_jogada, db_memoria, fim, jogada);
        end
        tick();
        tests_run++;
        if (db_contagem !== 4'd0 || db_jogada !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_hold: cnt=%0d jog=%b, want 0 0000", db_contagem, db_jogada);
        end
        idle_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_counter_wrap();
        logic [3:0] exp_cnt;
        zeraC = 1'b1; tick(); zeraC = 1'b0;
        tests_run++;
        if (db_contagem !== 4'd0 || fim !== 1'b0 || db_memoria !== rom_exp[0]) begin
            tests_failed++;
            $display("FAIL wrap_clear: cnt=%0d fim=%b mem=%b, want 0 0 %b", db_contagem, fim, db_memoria, rom_exp[0]);
        end
        contaC = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_cnt = 4'(i);
            tests_run++;
            if (db_contagem !== exp_cnt || fim !== (exp_cnt == 4'd15) || db_memoria !== rom_exp[exp_cnt]) begin
                tests_failed++;
                $display("FAIL wrap_step%0d: cnt=%0d fim=%b mem=%b, want %0d %b %b",
                         i, db_contagem, fim, db_memoria, exp_cnt, (exp_cnt == 4'd15), rom_exp[exp_cnt]);
            end
        end
        contaC = 1'b0;
        tick();
        tests_run++;
        if (db_contagem !== 4'd0) begin
            tests_failed++;
            $display("FAIL wrap_hold: cnt=%0d, want 0", db_contagem);
        end
    endtask

    task automatic test_counter_priority();
        set_counter(7);
        tests_run++;
        if (db_contagem !== 4'd7) begin
            tests_failed++;
            $display("FAIL prio_setup: cnt=%0d, want 7", db_contagem);
        end
        zeraC = 1'b1; contaC = 1'b1; tick(); zeraC = 1'b0; contaC = 1'b0;
        tests_run++;
        if (db_contagem !== 4'd0) begin
            tests_failed++;
            $display("FAIL prio_zerac: cnt=%0d, want 0", db_contagem);
        end
    endtask

    task automatic test_match();
        set_counter(3);
        chaves = 4'b1000; registraR = 1'b1; tick(); registraR = 1'b0;
        tests_run++;
        if (db_jogada !== 4'b1000 || igual !== 1'b1 || db_memoria !== 4'b1000) begin
            tests_failed++;
            $display("FAIL match_load: jog=%b igual=%b mem=%b, want 1000 1 1000", db_jogada, igual, db_memoria);
        end
        chaves = 4'b0010; tick();
        tests_run++;
        if (db_jogada !== 4'b1000 || igual !== 1'b1) begin
            tests_failed++;
            $display("FAIL match_hold: jog=%b igual=%b, want 1000 1", db_jogada, igual);
        end
        chaves = 4'b0000; tick();
    endtask

    task automatic test_mismatch();
        zeraC = 1'b1; tick(); zeraC = 1'b0;
        chaves = 4'b0010; registraR = 1'b1; tick(); registraR = 1'b0;
        tests_run++;
        if (db_jogada !== 4'b0010 || igual !== 1'b0 || db_contagem !== 4'd0) begin
            tests_failed++;
            $display("FAIL mismatch: jog=%b igual=%b cnt=%0d, want 0010 0 0", db_jogada, igual, db_contagem);
        end
        zeraR = 1'b1; registraR = 1'b1; tick(); zeraR = 1'b0; registraR = 1'b0;
        tests_run++;
        if (db_jogada !== 4'b0000) begin
            tests_failed++;
            $display("FAIL prio_zerar: jog=%b, want 0000", db_jogada);
        end
        // two keys at once load as-is and never match a one-hot word
        chaves = 4'b0011; registraR = 1'b1; tick(); registraR = 1'b0; chaves = 4'b0000;
        tests_run++;
        if (db_jogada !== 4'b0011 || igual !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_key: jog=%b igual=%b, want 0011 0", db_jogada, igual);
        end
        tick();
    endtask

    task automatic test_edge_detector();
        logic [3:0] pat [10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
        logic exp_pulse;
        int   pulses = 0;
        chaves = 4'b0000; tick();
        for (int i = 0; i < 10; i++) begin
            chaves = pat[i];
            #1;
            exp_pulse = (i == 0) || (i == 7);
            if (jogada === 1'b1) pulses++;
            tests_run++;
            if (jogada !== exp_pulse) begin
                tests_failed++;
                $display("FAIL edge_cycle%0d: jogada=%b, want %b", i, jogada, exp_pulse);
            end
            @(posedge clock); #1;
        end
        chaves = 4'b0000;
        tests_run++;
        if (pulses != 2) begin
            tests_failed++;
            $display("FAIL edge_count: pulses=%0d, want 2", pulses);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_counter_wrap();
        test_counter_priority();
        test_match();
        test_mismatch();
        test_edge_detector();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exp5_fluxo_dados.md
Name: exp5_fluxo_dados

Overview:
- Datapath companion of the game control unit. It executes the zeraC/contaC/zeraR/registraR commands and returns the fim, jogada and igual status signals.
- Holds the round position counter, the stored-sequence ROM, the player-move register and the key edge detector.
- One instance sits beside the control unit inside the game top level. Debug outputs drive the 7-segment displays.

Parameters:
- ADDR_W, 4, address width of the position counter and sequence ROM (depth 2**ADDR_W)
- DATA_W, 4, width of the key bus, ROM words and move register

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- zeraC  in  1  synchronous clear of the position counter
- contaC  in  1  synchronous increment of the position counter
- zeraR  in  1  synchronous clear of the move register
- registraR  in  1  synchronous load of the move register from chaves
- chaves  in  DATA_W  player keys, one-hot when pressed, 0 when released
- fim  out  1  counter at last address (2**ADDR_W-1)
- jogada  out  1  one-cycle pulse when a key press starts
- igual  out  1  move register equals the ROM word at the current address
- db_contagem  out  ADDR_W  current counter value
- db_memoria  out  DATA_W  ROM word at the current address
- db_jogada  out  DATA_W  move register contents

Behaviour:
- Reset:
  - While reset=0, asynchronously force counter=0, move register=0 and the edge-detector history flop=0.
  - Resulting outputs: db_contagem=0, db_jogada=0, jogada=0, fim=0, db_memoria=ROM[0]=0001, igual=0.
  - Reset asserted mid-round aborts the round immediately, regardless of the command inputs.
- Position counter (ADDR_W bits):
  - zeraC=1: counter becomes 0 on the next edge. zeraC has priority over contaC when both are 1.
  - contaC=1 and zeraC=0: increment by 1, wrapping from 2**ADDR_W-1 to 0.
  - Otherwise hold.
- fim:
  - Combinational: fim=1 exactly when counter == 2**ADDR_W-1.
  - No extra latency; fim is valid in the same cycle the counter reaches 15.
- Sequence ROM:
  - Asynchronous read, addressed by the counter; db_memoria = ROM[counter].
  - Fixed contents, addresses 0..15: 0001 0010 0100 1000 0100 0010 0001 0001 0010 0010 0100 0100 1000 1000 0001 0100.
- Move register (DATA_W bits):
  - zeraR=1: clear to 0 on the next edge. zeraR has priority over registraR when both are 1.
  - registraR=1 and zeraR=0: load chaves.
  - Otherwise hold.
- igual:
  - Combinational: igual = (move register == ROM[counter]).
  - Valid one cycle after the registraR edge, i.e. in the control unit's comparacao state.
- Edge detector:
  - The history flop samples press = OR-reduction of chaves every cycle.
  - jogada = press AND NOT history, so it is a single-cycle pulse on the first cycle a key is seen pressed.
  - Holding a key produces no further pulses. A new pulse requires chaves to return to 0 for at least one cycle.
  - Multiple keys pressed together count as one press. Their value is loaded as-is, and igual then fails against any one-hot ROM word.
- Timing and signal hygiene:
  - No internal synchronizer; chaves is assumed already synchronous and debounced upstream.
  - jogada may be combinationally dependent on chaves.
  - All outputs other than jogada, fim, igual and db_memoria come directly from flops.

Test Plan:
- Reset: pulse reset=0 mid-operation with counter=5 and register=0100 -> db_contagem=0, db_jogada=0, db_memoria=0001, fim=0, jogada=0 immediately, before any clock edge.
- Counter wrap: zeraC for 1 cycle, then contaC=1 for 16 cycles -> db_contagem steps 0..15 with fim=1 only at 15, then wraps to 0 with fim=0.
- Counter priority: zeraC=1 and contaC=1 together with counter=7 -> counter=0 after the edge.
- Match path: counter=3, chaves=1000, registraR for 1 cycle -> db_jogada=1000, igual=1. Then chaves=0010 with registraR=0 -> db_jogada still 1000, igual still 1.
- Mismatch and register priority: counter=0, chaves=0010, registraR=1 -> igual=0. Then zeraR=1 and registraR=1 together -> db_jogada=0000.
- Edge detector: hold chaves=0100 for 5 cycles, release for 2, press 0001 for 3 -> exactly two jogada pulses, each one cycle long, on the first cycle of each press.
